uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Host command controller for the glitcher FPGA. Sits between the UART core and the glitch engine, parses a byte-oriented command stream, maintains the glitch configuration register file, fires the arm strobe, and sequences response bytes back out through the UART transmitter one byte at a time.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1200000: maximum idle cycles between bytes of one command before abort (100 ms at 12 MHz).
- `ACK_BYTE`, default 8'h06: single-byte success reply.
- `NAK_BYTE`, default 8'h15: single-byte failure reply.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe from UART, byte received.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `rx_error` in 1: one-cycle strobe from UART, framing error.
- `tx_start` out 1: one-cycle request to UART to send `tx_data`.
- `tx_data` out 8: byte to send, held stable from `tx_start` until the byte completes.
- `tx_busy` in 1: UART transmitter not idle.
- `glitch_busy` in 1: glitch engine currently armed or firing.
- `arm` out 1: one-cycle arm strobe to the glitch engine.
- `cfg_delay`, `cfg_width`, `cfg_count`, `cfg_ctrl` out 32 each: register file contents, addresses 0 to 3.

## Operation

- Protocol: opcode byte, then arguments. Multi-byte values are LSB first.
  - 0x01 WRITE: addr, d0..d3. Writes reg[addr], replies ACK.
  - 0x02 READ: addr. Replies 4 bytes of reg[addr].
  - 0x03 ARM: no arguments. Pulses `arm` and replies ACK. If `glitch_busy`, no pulse and replies NAK.
  - Any other opcode: replies NAK immediately, no arguments consumed.
- Address check: addr > 3 replies NAK, but only after the full command has been received, so WRITE still consumes all 4 data bytes. No register changes.
- States:
  - IDLE: waits for opcode.
  - GET_ADDR
  - GET_DATA: 2-bit byte counter, shifts into a 32-bit assembly register.
  - EXEC: single cycle. Performs the write or arm and selects the reply.
  - TX_LOAD: asserts `tx_start` for one cycle.
  - TX_WAIT_START: waits for `tx_busy`=1.
  - TX_WAIT_DONE: waits for `tx_busy`=0. Then either the next reply byte goes to TX_LOAD, or the state returns to IDLE.
- A 2-bit reply counter selects the READ byte; ACK and NAK are one byte.
- Bytes arriving while in EXEC or any TX state are dropped.
- `rx_error` in GET_ADDR or GET_DATA: abort and reply NAK. `rx_error` in IDLE is ignored.
- Timeout: a 21-bit counter clears on every `rx_valid` and runs only in GET_ADDR and GET_DATA. Reaching `TIMEOUT_CYCLES` returns to IDLE silently.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-transmission abandons the reply. The UART itself finishes the byte in flight.

## Timing

- The last command byte's `rx_valid` is at cycle N. EXEC is at N+1.
- `arm` is high in cycle N+1 only.
- The cfg register is updated at the edge ending N+1, so the new value is visible from N+2.
- `tx_start` is high in cycle N+2.
- `tx_data` is valid from N+2 and held until TX_WAIT_DONE exits.
- The UART raises `tx_busy` one cycle after accepting the byte. TX_WAIT_START must therefore not test `tx_busy` in the same cycle as `tx_start`.
- Consecutive reply bytes: the next `tx_start` comes 1 cycle after `tx_busy` falls.
- `rx_valid` and `rx_error` in the same cycle: the error wins.

## Structure

- Shared package `glitch_pkg` holds:
  - opcode constants;
  - `ACK_BYTE` and `NAK_BYTE` defaults;
  - register address constants `REG_DELAY`=0, `REG_WIDTH`=1, `REG_COUNT`=2, `REG_CTRL`=3;
  - the state encoding.
- The only sub-module is `uart_tx_seq`: the TX_LOAD/WAIT handshake plus the reply byte counter. It takes a 32-bit reply word and a length of 1 or 4, and returns done.

## Test plan

- WRITE 01 00 78 56 34 12 → `cfg_delay`=32'h12345678 from N+2, one reply byte 0x06, `arm` never high.
- WRITE to reg 2, then READ 02 02 → reply bytes in order 78 56 34 12. Each `tx_start` is a single cycle, and the next one waits for `tx_busy` to fall.
- ARM 03 with `glitch_busy`=0 → `arm` pulses exactly 1 cycle at N+1, reply 06. Repeat with `glitch_busy`=1 → no pulse, reply 15.
- Opcode 0x7F → reply 15 immediately. WRITE 01 05 + 4 bytes → reply 15 only after the 4th data byte, and all cfg registers unchanged.
- WRITE 01 01 AA, then no bytes for `TIMEOUT_CYCLES` → return to IDLE, no reply. A following full WRITE to reg 1 succeeds with correct data. `rx_error` injected mid-WRITE → reply 15, registers unchanged.
- `rst` asserted during the second byte of a READ reply → next cycle all outputs 0 and state IDLE, and a subsequent READ returns 00 00 00 00.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitcher host interface: opcodes, reply bytes,
// register addresses and the controller state encodings.
package glitch_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_ARM   = 8'h03;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

  localparam logic [1:0] REG_DELAY = 2'd0;
  localparam logic [1:0] REG_WIDTH = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_GET_ADDR,
    CMD_GET_DATA,
    CMD_EXEC,
    CMD_TX
  } cmd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_START,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_tx_seq.sv
// Sends a 1- or 4-byte reply word LSB first through the UART transmitter,
// one start strobe per byte, and pulses done after the last byte completes.
module uart_tx_seq
  import glitch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [2:0]  len,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  tx_state_t   state, state_nxt;
  logic [31:0] word_q;
  logic [1:0]  byte_cnt;
  logic [1:0]  last_idx;
  logic        last;

  assign last = (byte_cnt == last_idx);

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    done      = 1'b0;
    unique case (state)
      TX_IDLE:       if (start) state_nxt = TX_LOAD;
      TX_LOAD: begin
        tx_start  = 1'b1;
        state_nxt = TX_WAIT_START;
      end
      // busy rises one cycle after the strobe, so it is only looked at from here on
      TX_WAIT_START: if (tx_busy) state_nxt = TX_WAIT_DONE;
      TX_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last) begin
            done      = 1'b1;
            state_nxt = TX_IDLE;
          end else begin
            state_nxt = TX_LOAD;
          end
        end
      end
      default:       state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      byte_cnt <= '0;
      last_idx <= '0;
      tx_data  <= '0;
    end else if (state == TX_IDLE && start) begin
      word_q   <= word;
      byte_cnt <= '0;
      last_idx <= (len == 3'd4) ? 2'd3 : 2'd0;
      tx_data  <= word[7:0];
    end else if (state == TX_WAIT_DONE && !tx_busy && !last) begin
      // tx_data stays put for the whole byte and only advances between bytes
      word_q   <= {8'd0, word_q[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
      tx_data  <= word_q[15:8];
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command parser for the glitcher: decodes WRITE/READ/ARM byte commands,
// owns the four configuration registers and hands replies to uart_tx_seq.
module uart_cmd_ctrl
  import glitch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEFAULT_NAK_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        glitch_busy,
  output logic        arm,
  output logic [31:0] cfg_delay,
  output logic [31:0] cfg_width,
  output logic [31:0] cfg_count,
  output logic [31:0] cfg_ctrl
);

  localparam logic [20:0] TIMEOUT_LIMIT = 21'(TIMEOUT_CYCLES);

  cmd_state_t  state, state_nxt;
  logic [7:0]  opcode;
  logic [7:0]  addr;
  logic [31:0] data_asm;
  logic [1:0]  byte_cnt;
  logic        abort;
  logic [20:0] idle_cnt;
  logic [31:0] regs [4];

  logic        byte_in;
  logic        addr_ok;
  logic        timeout;
  logic        wr_en;
  logic [31:0] reply_word;
  logic [2:0]  reply_len;
  logic        tx_done;

  // a framing error in the same cycle as a byte discards the byte
  assign byte_in = rx_valid && !rx_error;
  assign addr_ok = (addr < 8'd4);
  assign timeout = (idle_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= CMD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CMD_IDLE:
        if (byte_in)
          state_nxt = (rx_data == OP_WRITE || rx_data == OP_READ) ? CMD_GET_ADDR : CMD_EXEC;
      CMD_GET_ADDR:
        if (rx_error)      state_nxt = CMD_EXEC;
        else if (rx_valid) state_nxt = (opcode == OP_WRITE) ? CMD_GET_DATA : CMD_EXEC;
        else if (timeout)  state_nxt = CMD_IDLE;
      CMD_GET_DATA:
        if (rx_error)      state_nxt = CMD_EXEC;
        else if (rx_valid) state_nxt = (byte_cnt == 2'd3) ? CMD_EXEC : CMD_GET_DATA;
        else if (timeout)  state_nxt = CMD_IDLE;
      CMD_EXEC:            state_nxt = CMD_TX;
      CMD_TX:              if (tx_done) state_nxt = CMD_IDLE;
      default:             state_nxt = CMD_IDLE;
    endcase
  end

  // Reply selection and side effects, all confined to the single EXEC cycle.
  always_comb begin
    reply_word = {24'd0, NAK_BYTE};
    reply_len  = 3'd1;
    arm        = 1'b0;
    wr_en      = 1'b0;
    if (state == CMD_EXEC && !abort) begin
      case (opcode)
        OP_WRITE: if (addr_ok) begin
          wr_en      = 1'b1;
          reply_word = {24'd0, ACK_BYTE};
        end
        OP_READ: if (addr_ok) begin
          reply_word = regs[addr[1:0]];
          reply_len  = 3'd4;
        end
        OP_ARM: if (!glitch_busy) begin
          arm        = 1'b1;
          reply_word = {24'd0, ACK_BYTE};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode   <= '0;
      addr     <= '0;
      data_asm <= '0;
      byte_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      case (state)
        CMD_IDLE: begin
          abort    <= 1'b0;
          byte_cnt <= '0;
          if (byte_in) opcode <= rx_data;
        end
        CMD_GET_ADDR: begin
          if (rx_error)      abort <= 1'b1;
          else if (rx_valid) addr  <= rx_data;
        end
        CMD_GET_DATA: begin
          if (rx_error) begin
            abort <= 1'b1;
          end else if (rx_valid) begin
            data_asm <= {rx_data, data_asm[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte watchdog: only counts while a command is partially received.
  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if ((state == CMD_GET_ADDR || state == CMD_GET_DATA) && !rx_valid)
      idle_cnt <= idle_cnt + 21'd1;
    else
      idle_cnt <= '0;
  end

  // NOTE: this small register file is reset because it drives outputs that must come up at zero; it is flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[addr[1:0]] <= data_asm;
    end
  end

  assign cfg_delay = regs[REG_DELAY];
  assign cfg_width = regs[REG_WIDTH];
  assign cfg_count = regs[REG_COUNT];
  assign cfg_ctrl  = regs[REG_CTRL];

  uart_tx_seq u_tx_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (state == CMD_EXEC),
    .word     (reply_word),
    .len      (reply_len),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: a UART transmitter model plus a command-level
// reference model of the register file and reply bytes.
module tb_uart_cmd_ctrl;

  localparam int unsigned TO  = 64;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_error, tx_start, tx_busy, glitch_busy, arm;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] cfg_delay, cfg_width, cfg_count, cfg_ctrl;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0]  tx_log[$];
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_q[$];
  bit          exp_arm;
  logic [31:0] model_regs[4];

  bit          busy_pending = 0;
  bit          first_byte   = 1;
  bit          hold_check   = 0;
  int          busy_left    = 0;
  int          fall_cyc     = 0;
  int          arm_cnt      = 0;
  int          arm_cyc      = 0;
  logic [7:0]  held         = 8'h00;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_error    (rx_error),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .glitch_busy (glitch_busy),
    .arm         (arm),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_count   (cfg_count),
    .cfg_ctrl    (cfg_ctrl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy rises one cycle after the strobe and lasts a random time.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) hold_check = 0;
      if (arm === 1'b1) begin
        arm_cnt++;
        arm_cyc = cyc;
      end
      if (tx_start === 1'b1) begin
        total++;
        if (tx_busy || busy_pending) $display("FAIL tx_start_while_busy cycle %0d", cyc);
        else passed++;
        if (!first_byte) begin
          total++;
          if (cyc != fall_cyc + 1)
            $display("FAIL next_start_gap got cycle %0d want %0d", cyc, fall_cyc + 1);
          else passed++;
        end
        first_byte = 0;
        tx_log.push_back(tx_data);
        held = tx_data;
        hold_check = 1;
        busy_pending = 1;
      end else if (busy_pending) begin
        busy_pending = 0;
        tx_busy = 1'b1;
        busy_left = $urandom_range(2, 6);
      end else if (tx_busy) begin
        if (hold_check) begin
          total++;
          if (tx_data !== held) $display("FAIL tx_data_held got %h want %h", tx_data, held);
          else passed++;
        end
        busy_left--;
        if (busy_left == 0) begin
          tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] cfg_out(input int i);
    case (i)
      0:       return cfg_delay;
      1:       return cfg_width;
      2:       return cfg_count;
      default: return cfg_ctrl;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Reference model: command bytes in, expected reply bytes and arm out.
  task automatic model_cmd();
    int          a;
    logic [31:0] d;
    exp_q.delete();
    exp_arm = 0;
    case (cmd_q[0])
      8'h01: begin
        a = int'(cmd_q[1]);
        d = {cmd_q[5], cmd_q[4], cmd_q[3], cmd_q[2]};
        if (a < 4) begin
          model_regs[a] = d;
          exp_q.push_back(ACK);
        end else exp_q.push_back(NAK);
      end
      8'h02: begin
        a = int'(cmd_q[1]);
        if (a < 4) for (int k = 0; k < 4; k++) exp_q.push_back(8'(model_regs[a] >> (8 * k)));
        else exp_q.push_back(NAK);
      end
      8'h03: begin
        if (glitch_busy) exp_q.push_back(NAK);
        else begin
          exp_q.push_back(ACK);
          exp_arm = 1;
        end
      end
      default: exp_q.push_back(NAK);
    endcase
  endtask

  task automatic wait_uart_idle();
    for (int i = 0; i < 200 && (tx_busy || busy_pending); i++) tick();
  endtask

  task automatic wait_reply(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_log.size() >= n && !tx_busy && !busy_pending) begin
        ok = 1;
        break;
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic run_cmd(input string name, input bit inject);
    logic [31:0] pre[4];
    int          n;
    bit          ok;
    wait_uart_idle();
    for (int i = 0; i < 4; i++) pre[i] = model_regs[i];
    model_cmd();
    tx_log.delete();
    arm_cnt = 0;
    first_byte = 1;
    foreach (cmd_q[i]) begin
      if (i > 0) repeat ($urandom_range(0, 2)) tick();
      send_byte(cmd_q[i]);
    end
    n = cyc - 1;
    total++;
    if (arm !== exp_arm) $display("FAIL %s arm_at_n1 got %b want %b", name, arm, exp_arm);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cfg_out(i) !== pre[i]) $display("FAIL %s cfg%0d_at_n1 got %h want %h", name, i, cfg_out(i), pre[i]);
      else passed++;
    end
    tick();
    total++;
    if (tx_start !== 1'b1) $display("FAIL %s tx_start_at_n2 got %b want 1", name, tx_start);
    else passed++;
    total++;
    if (tx_data !== exp_q[0]) $display("FAIL %s tx_data_at_n2 got %h want %h", name, tx_data, exp_q[0]);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cfg_out(i) !== model_regs[i]) $display("FAIL %s cfg%0d_at_n2 got %h want %h", name, i, cfg_out(i), model_regs[i]);
      else passed++;
    end
    if (inject) send_byte(8'h03);
    wait_reply(exp_q.size(), ok);
    total++;
    if (!ok) $display("FAIL %s reply_timeout got %0d bytes want %0d", name, tx_log.size(), exp_q.size());
    else passed++;
    total++;
    if (tx_log.size() != exp_q.size()) $display("FAIL %s reply_len got %0d want %0d", name, tx_log.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      total++;
      if (tx_log[i] !== exp_q[i]) $display("FAIL %s reply_byte%0d got %h want %h", name, i, tx_log[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (arm_cnt != int'(exp_arm)) $display("FAIL %s arm_pulses got %0d want %0d", name, arm_cnt, exp_arm);
    else passed++;
    if (exp_arm) begin
      total++;
      if (arm_cyc != n + 1) $display("FAIL %s arm_cycle got %0d want %0d", name, arm_cyc, n + 1);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00; glitch_busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    total++;
    if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else passed++;
    total++;
    if (arm !== 1'b0) $display("FAIL reset_arm got %b want 0", arm); else passed++;
    total++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cfg_out(i) !== 32'h0) $display("FAIL reset_cfg%0d got %h want 0", i, cfg_out(i)); else passed++;
    end
  endtask

  task automatic test_write();
    cmd_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_cmd("write_delay", 0);
    total++;
    if (cfg_delay !== 32'h12345678) $display("FAIL write_delay_value got %h want 12345678", cfg_delay); else passed++;
  endtask

  task automatic test_read();
    cmd_q = '{8'h01, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
    run_cmd("write_count", 0);
    cmd_q = '{8'h02, 8'h02};
    run_cmd("read_count", 0);
    cmd_q = '{8'h02, 8'h00};
    run_cmd("read_drop_rx", 1);
  endtask

  task automatic test_arm();
    glitch_busy = 1'b0;
    cmd_q = '{8'h03};
    run_cmd("arm_idle", 0);
    glitch_busy = 1'b1;
    run_cmd("arm_busy", 0);
    glitch_busy = 1'b0;
  endtask

  task automatic test_bad();
    cmd_q = '{8'h7F};
    run_cmd("bad_opcode", 0);
    cmd_q = '{8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd("write_bad_addr", 0);
    cmd_q = '{8'h02, 8'h09};
    run_cmd("read_bad_addr", 0);
  endtask

  task automatic test_timeout();
    wait_uart_idle();
    tx_log.delete();
    arm_cnt = 0;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hAA);
    repeat (TO + 20) tick();
    total++;
    if (tx_log.size() != 0) $display("FAIL timeout_silent got %0d bytes want 0", tx_log.size()); else passed++;
    total++;
    if (cfg_width !== model_regs[1]) $display("FAIL timeout_cfg got %h want %h", cfg_width, model_regs[1]); else passed++;
    cmd_q = '{8'h01, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_cmd("write_after_timeout", 0);
    total++;
    if (cfg_width !== 32'hDEADBEEF) $display("FAIL timeout_write_value got %h want deadbeef", cfg_width); else passed++;
  endtask

  task automatic test_rx_error();
    logic [31:0] pre[4];
    int          n;
    bit          ok;
    wait_uart_idle();
    for (int i = 0; i < 4; i++) pre[i] = model_regs[i];
    tx_log.delete();
    arm_cnt = 0;
    first_byte = 1;
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_error = 1'b1;
    send_byte(8'h33);
    rx_error = 1'b0;
    n = cyc - 1;
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== NAK)
      $display("FAIL rx_error_reply_at_n2 got start=%b data=%h want start=1 data=%h", tx_start, tx_data, NAK);
    else passed++;
    wait_reply(1, ok);
    total++;
    if (!ok || tx_log.size() != 1) $display("FAIL rx_error_reply_len got %0d want 1", tx_log.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cfg_out(i) !== pre[i]) $display("FAIL rx_error_cfg%0d got %h want %h", i, cfg_out(i), pre[i]); else passed++;
    end
    // an error strobe while idle must be ignored
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    tick();
    total++;
    if (tx_start !== 1'b0) $display("FAIL rx_error_idle got tx_start=%b want 0 (cycle %0d)", tx_start, n); else passed++;
    cmd_q = '{8'h02, 8'h03};
    run_cmd("read_after_error", 0);
  endtask

  task automatic test_random();
    logic [7:0] op;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: cmd_q = '{8'h01, 8'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        1: cmd_q = '{8'h02, 8'($urandom_range(0, 5))};
        2: begin
          glitch_busy = 1'($urandom_range(0, 1));
          cmd_q = '{8'h03};
        end
        default: begin
          do op = 8'($urandom); while (op == 8'h01 || op == 8'h02 || op == 8'h03);
          cmd_q = '{op};
        end
      endcase
      run_cmd("random", 0);
    end
    glitch_busy = 1'b0;
  endtask

  task automatic test_reset_mid_reply();
    bit ok;
    cmd_q = '{8'h01, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11};
    run_cmd("write_before_reset", 0);
    wait_uart_idle();
    tx_log.delete();
    first_byte = 1;
    send_byte(8'h02);
    send_byte(8'h02);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_log.size() >= 2 && tx_busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) $display("FAIL reset_mid_second_byte got %0d bytes want 2", tx_log.size()); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    total++;
    if (tx_start !== 1'b0 || arm !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_mid_outputs got start=%b arm=%b data=%h want 0", tx_start, arm, tx_data);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cfg_out(i) !== 32'h0) $display("FAIL reset_mid_cfg%0d got %h want 0", i, cfg_out(i)); else passed++;
    end
    cmd_q = '{8'h02, 8'h02};
    run_cmd("read_after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arm();
    test_bad();
    test_timeout();
    test_rx_error();
    test_random();
    test_reset_mid_reply();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
